// File: rtl/binary_grid_packer_if.sv
// Pixel-in / row-out bus for the grid packer.
// The slave side is the packer. The master side is the pixel source plus the row consumer.
interface binary_grid_packer_if #(
  parameter int GRID_W = 25
);
  logic              bit_in;
  logic              bit_valid;
  logic              frame_start;
  logic [GRID_W-1:0] row_data;
  logic [4:0]        row_index;
  logic              row_last;
  logic              row_valid;
  logic              row_ready;

  modport slave (
    input  bit_in, bit_valid, frame_start, row_ready,
    output row_data, row_index, row_last, row_valid
  );

  modport master (
    output bit_in, bit_valid, frame_start, row_ready,
    input  row_data, row_index, row_last, row_valid
  );
endinterface

// File: rtl/binary_grid_packer.sv
// Packs a raster 1-bit pixel stream into GRID_W-bit row words.
// Completed rows are queued in a small FIFO behind a valid/ready port.
// The pixel input has no backpressure: a row that completes while the FIFO is full is dropped.
module binary_grid_packer #(
  parameter int GRID_W     = 25,
  parameter int GRID_H     = 25,
  parameter int FIFO_DEPTH = 4,
  localparam int PW        = $clog2(FIFO_DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  binary_grid_packer_if.slave   bus,
  output logic                  frame_done,
  output logic                  overflow,
  output logic [CW-1:0]         fifo_count
);

  typedef struct packed {
    logic [GRID_W-1:0] data;
    logic [4:0]        idx;
    logic              last;
  } row_t;

  logic [4:0]        col_q, col_d, row_q, row_d;
  logic [GRID_W-1:0] word_q, word_d;
  row_t              mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d, fd_q, fd_d;

  // frame_start resets the grid position for this cycle's bit.
  logic [4:0]        col_eff, row_eff;
  logic [GRID_W-1:0] word_base, word_next;
  logic              row_end, frame_end, push, pop, full, wr, drop;
  row_t              push_entry;

  // Grid position, packing, and FIFO push/pop decisions.
  always_comb begin
    col_eff   = bus.frame_start ? 5'd0 : col_q;
    row_eff   = bus.frame_start ? 5'd0 : row_q;
    word_base = bus.frame_start ? '0 : word_q;
    word_next = word_base;
    word_next[col_eff] = bus.bit_in;
    row_end   = (col_eff == 5'(GRID_W - 1));
    frame_end = row_end && (row_eff == 5'(GRID_H - 1));
    push      = bus.bit_valid && row_end;
    pop       = (cnt_q != '0) && bus.row_ready;
    full      = (cnt_q == CW'(FIFO_DEPTH));
    // When the FIFO is full, a simultaneous pop frees a slot for the push.
    wr        = push && (!full || pop);
    drop      = push && full && !pop;

    push_entry.data = word_next;
    push_entry.idx  = row_eff;
    push_entry.last = (row_eff == 5'(GRID_H - 1));

    col_d  = col_eff;
    row_d  = row_eff;
    word_d = word_base;
    if (bus.bit_valid) begin
      if (row_end) begin
        col_d  = 5'd0;
        word_d = '0;
        row_d  = frame_end ? 5'd0 : 5'(row_eff + 5'd1);
      end else begin
        col_d  = 5'(col_eff + 5'd1);
        word_d = word_next;
      end
    end

    cnt_d = cnt_q + CW'(wr) - CW'(pop);
    // frame_start clears the sticky flag, but a drop in the same cycle still sets it.
    ovf_d = (ovf_q && !bus.frame_start) || drop;
    fd_d  = bus.bit_valid && frame_end;
  end

  // State registers and FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      word_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      fd_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      word_q <= word_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      fd_q   <= fd_d;
      if (wr) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // The head entry is presented directly from storage. It holds until popped.
  row_t head;
  assign head          = mem_q[rd_ptr_q];
  assign bus.row_valid = (cnt_q != '0);
  assign bus.row_data  = head.data;
  assign bus.row_index = head.idx;
  assign bus.row_last  = head.last;
  assign fifo_count    = cnt_q;
  assign overflow      = ovf_q;
  assign frame_done    = fd_q;

endmodule

// File: tb/tb_binary_grid_packer.sv
// Directed and random stimulus for binary_grid_packer.
// A pixel-count reference model with a queue of expected rows checks every cycle.
module tb_binary_grid_packer;
  localparam int W = 25, H = 25, D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_done, overflow;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  binary_grid_packer_if #(.GRID_W(W)) bus ();

  binary_grid_packer #(.GRID_W(W), .GRID_H(H), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .frame_done (frame_done),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  typedef struct {
    logic [W-1:0] data;
    int           idx;
    bit           last;
  } ent_t;

  ent_t         q[$];
  int           pix;
  logic [W-1:0] cur;
  bit           m_ovf, m_fd;
  int           checks = 0, failures = 0, rows_out = 0, fd_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("row_valid", 64'(bus.row_valid), 64'(q.size() > 0));
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("frame_done", 64'(frame_done), 64'(m_fd));
    if (q.size() > 0) begin
      chk("row_data", 64'(bus.row_data), 64'(q[0].data));
      chk("row_index", 64'(bus.row_index), 64'(q[0].idx));
      chk("row_last", 64'(bus.row_last), 64'(q[0].last));
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic cyc(input bit fs, input bit bv, input bit b, input bit rdy);
    bit   pop;
    int   col, row;
    ent_t e;
    bus.frame_start = fs;
    bus.bit_valid   = bv;
    bus.bit_in      = b;
    bus.row_ready   = rdy;
    pop = (q.size() > 0) && rdy;
    @(posedge clk);
    #1;
    if (pop) begin
      void'(q.pop_front());
      rows_out++;
    end
    if (fs) begin
      pix = 0; cur = '0; m_ovf = 0;
    end
    m_fd = 0;
    if (bv) begin
      col = pix % W;
      row = pix / W;
      cur[col] = b;
      pix++;
      if (col == W - 1) begin
        e.data = cur; e.idx = row; e.last = (row == H - 1);
        if (q.size() < D) q.push_back(e);
        else m_ovf = 1;
        cur = '0;
        if (row == H - 1) begin
          m_fd = 1; pix = 0;
        end
      end
    end
    if (m_fd) fd_cnt++;
    check_all();
    bus.frame_start = 1'b0;
    bus.bit_valid   = 1'b0;
  endtask

  task automatic rbits(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 1, 1'($urandom), rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1);
  endtask

  // Asynchronous reset asserted between edges, checked before any clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    q.delete(); pix = 0; cur = '0; m_ovf = 0; m_fd = 0;
    #1;
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bus.bit_in = 0; bus.bit_valid = 0; bus.frame_start = 0; bus.row_ready = 0;
    pix = 0; cur = '0; m_ovf = 0; m_fd = 0;
    #3;
    check_all();
    chk("reset_row_data", 64'(bus.row_data), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: alternating 1,0,... row
    for (int i = 0; i < W; i++) begin
      cyc(0, 1, (i % 2) == 0, 0);
      if (i == W - 2) chk("t1_not_yet_valid", 64'(bus.row_valid), 64'd0);
    end
    chk("t1_valid", 64'(bus.row_valid), 64'd1);
    chk("t1_data", 64'(bus.row_data), 64'h1555555);
    chk("t1_index", 64'(bus.row_index), 64'd0);
    chk("t1_last", 64'(bus.row_last), 64'd0);
    idle(4);

    // 2: full frame with gaps, ready held high
    rows_out = 0; fd_cnt = 0;
    cyc(1, 1, 1'($urandom), 1);
    for (int n = 1; n < W * H; ) begin
      if ($urandom_range(3, 0) != 0) begin
        cyc(0, 1, 1'($urandom), 1); n++;
      end else cyc(0, 0, 0, 1);
    end
    idle(4);
    chk("t2_rows_out", 64'(rows_out), 64'd25);
    chk("t2_frame_done_pulses", 64'(fd_cnt), 64'd1);
    chk("t2_overflow", 64'(overflow), 64'd0);

    // 3: stall for 6 rows, rows 4 and 5 dropped, then drain
    cyc(1, 1, 1'($urandom), 0);
    rbits(6 * W - 1, 0);
    chk("t3_count_full", 64'(fifo_count), 64'd4);
    chk("t3_overflow", 64'(overflow), 64'd1);
    rows_out = 0;
    idle(6);
    chk("t3_drained", 64'(rows_out), 64'd4);

    // 4: full FIFO, pop in the same cycle that row 4 completes
    cyc(1, 1, 1'($urandom), 0);
    rbits(5 * W - 2, 0);
    chk("t4_count_before", 64'(fifo_count), 64'd4);
    cyc(0, 1, 1'($urandom), 1);
    chk("t4_count_after", 64'(fifo_count), 64'd4);
    chk("t4_overflow", 64'(overflow), 64'd0);
    idle(6);

    // 5: frame_start discards a partial row and clears overflow
    cyc(1, 1, 1'($urandom), 0);
    rbits(6 * W - 1, 0);
    idle(6);
    rbits(10, 1);
    chk("t5_ovf_set", 64'(overflow), 64'd1);
    cyc(1, 0, 0, 1);
    chk("t5_ovf_clear", 64'(overflow), 64'd0);
    rbits(W, 0);
    chk("t5_valid", 64'(bus.row_valid), 64'd1);
    chk("t5_index", 64'(bus.row_index), 64'd0);
    idle(3);

    // frame_start together with a bit: the bit lands at column 0
    rbits(7, 1);
    cyc(1, 1, 1, 0);
    for (int i = 1; i < W; i++) cyc(0, 1, 0, 0);
    chk("fsbv_index", 64'(bus.row_index), 64'd0);
    chk("fsbv_data", 64'(bus.row_data), 64'd1);
    idle(3);

    // 6: reset mid-row with 2 rows queued
    cyc(1, 1, 1'($urandom), 0);
    rbits(2 * W + 6, 0);
    chk("t6_queued", 64'(fifo_count), 64'd2);
    async_reset();
    chk("t6_valid_cleared", 64'(bus.row_valid), 64'd0);
    chk("t6_count_cleared", 64'(fifo_count), 64'd0);
    rbits(W, 1);
    chk("t6_index", 64'(bus.row_index), 64'd0);
    idle(3);

    // Random traffic: sparse frame_start, random valid and ready
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(199, 0) == 0, $urandom_range(4, 0) != 0, 1'($urandom),
          1'($urandom));
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
